// File: rtl/proximity_pkg.sv
// Shared types for the proximity guard: the per-channel qualification state,
// the motion-command encoding, and the distance sample width.
package proximity_pkg;

  localparam int MM_W = 12;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    ARMING    = 2'd1,
    BLOCKED   = 2'd2,
    RELEASING = 2'd3
  } prox_state_t;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2,
    DIR_RSVD = 2'd3
  } dir_t;

endpackage

// File: rtl/proximity_channel.sv
// One sonar direction. Qualifies raw distance samples with a confirm count and
// near/far hysteresis, and runs a staleness watchdog that forces stop when no
// usable sample has arrived recently.
//   clk, rst : clock, synchronous active-high reset
//   valid    : 1-cycle pulse, mm carries a sample
//   mm       : distance in mm; 0 means "no echo" and is ignored
//   stop     : registered; obstacle confirmed (BLOCKED/RELEASING) or channel stale
//   stale    : registered; no accepted sample within STALE_CYC cycles
module proximity_channel
  import proximity_pkg::*;
#(
  parameter int NEAR_MM   = 1000,
  parameter int FAR_MM    = 1200,
  parameter int CONFIRM_N = 3,
  parameter int STALE_CYC = 10_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [MM_W-1:0] mm,
  output logic            stop,
  output logic            stale
);

  localparam int CNT_W = $clog2(CONFIRM_N + 1);
  localparam int TMR_W = $clog2(STALE_CYC + 1);

  localparam logic [MM_W-1:0]  NEAR_L  = MM_W'(NEAR_MM);
  localparam logic [MM_W-1:0]  FAR_L   = MM_W'(FAR_MM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CONFIRM_N);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_TOP = TMR_W'(STALE_CYC);

  prox_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             stale_q, stale_d;
  logic             stop_q, stop_d;

  logic accepted;
  logic is_near;
  logic is_far;

  always_comb begin
    // A zero distance is a missed echo: it neither moves the FSM nor feeds the watchdog.
    accepted = valid && (mm != '0);
    is_near  = (mm < NEAR_L);
    is_far   = (mm >= FAR_L);

    state_d = state_q;
    cnt_d   = cnt_q;

    if (accepted) begin
      case (state_q)
        CLEAR: begin
          if (is_near) begin
            if (CONFIRM_N == 1) begin
              state_d = BLOCKED;
              cnt_d   = '0;
            end else begin
              state_d = ARMING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ARMING: begin
          if (is_near) begin
            // cnt never exceeds CONFIRM_N-1 here, so the increment cannot wrap.
            if ((cnt_q + CNT_ONE) == CNT_TOP) begin
              state_d = BLOCKED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (is_far) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
        BLOCKED: begin
          if (is_far) begin
            if (CONFIRM_N == 1) begin
              state_d = CLEAR;
              cnt_d   = '0;
            end else begin
              state_d = RELEASING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        RELEASING: begin
          if (is_far) begin
            if ((cnt_q + CNT_ONE) == CNT_TOP) begin
              state_d = CLEAR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (is_near) begin
            state_d = BLOCKED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      endcase
    end

    // Watchdog: saturating idle counter. An accepted sample always beats expiry.
    if (accepted) begin
      tmr_d = '0;
    end else if (tmr_q == TMR_TOP) begin
      tmr_d = tmr_q;
    end else begin
      tmr_d = tmr_q + TMR_ONE;
    end

    // stale is sticky until a sample arrives, so the post-reset stale state holds
    // even though the timer restarts from zero.
    stale_d = accepted ? 1'b0 : (stale_q || (tmr_q == TMR_TOP));

    stop_d = (state_d == BLOCKED) || (state_d == RELEASING) || stale_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      tmr_q   <= '0;
      stale_q <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      stale_q <= stale_d;
      stop_q  <= stop_d;
    end
  end

  assign stop  = stop_q;
  assign stale = stale_q;

endmodule

// File: rtl/proximity_guard.sv
// Proximity guard: qualifies front and back sonar samples independently and
// grants a registered motion permit for the requested direction. Fail-safe:
// missing or old sensor data forces stop on that side.
//   clk, rst              : clock, synchronous active-high reset
//   front_valid/front_mm  : front sample pulse and distance (mm)
//   back_valid/back_mm    : back sample pulse and distance (mm)
//   cmd_dir               : 00 idle, 01 forward, 10 reverse, 11 reserved
//   stop_front/stop_back  : obstacle confirmed or channel stale
//   stale_front/stale_back: no accepted sample within STALE_MS
//   motion_ok             : requested direction currently permitted
module proximity_guard
  import proximity_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int NEAR_MM   = 1000,
  parameter int FAR_MM    = 1200,
  parameter int CONFIRM_N = 3,
  parameter int STALE_MS  = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            front_valid,
  input  logic [MM_W-1:0] front_mm,
  input  logic            back_valid,
  input  logic [MM_W-1:0] back_mm,
  input  logic [1:0]      cmd_dir,
  output logic            stop_front,
  output logic            stop_back,
  output logic            stale_front,
  output logic            stale_back,
  output logic            motion_ok
);

  localparam int STALE_CYC = CLK_HZ / 1000 * STALE_MS;

  logic motion_ok_q, motion_ok_d;

  proximity_channel #(
    .NEAR_MM  (NEAR_MM),
    .FAR_MM   (FAR_MM),
    .CONFIRM_N(CONFIRM_N),
    .STALE_CYC(STALE_CYC)
  ) u_front (
    .clk  (clk),
    .rst  (rst),
    .valid(front_valid),
    .mm   (front_mm),
    .stop (stop_front),
    .stale(stale_front)
  );

  proximity_channel #(
    .NEAR_MM  (NEAR_MM),
    .FAR_MM   (FAR_MM),
    .CONFIRM_N(CONFIRM_N),
    .STALE_CYC(STALE_CYC)
  ) u_back (
    .clk  (clk),
    .rst  (rst),
    .valid(back_valid),
    .mm   (back_mm),
    .stop (stop_back),
    .stale(stale_back)
  );

  // Permit is built from the already-registered stop flags, adding one more
  // cycle of latency from a sample to motion_ok.
  always_comb begin
    motion_ok_d = 1'b0;
    case (dir_t'(cmd_dir))
      DIR_IDLE: motion_ok_d = 1'b1;
      DIR_FWD:  motion_ok_d = !stop_front;
      DIR_REV:  motion_ok_d = !stop_back;
      default:  motion_ok_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      motion_ok_q <= 1'b0;
    end else begin
      motion_ok_q <= motion_ok_d;
    end
  end

  assign motion_ok = motion_ok_q;

endmodule

// File: tb/tb_proximity_guard.sv
module tb_proximity_guard;

  localparam int NEAR = 1000;
  localparam int FAR  = 1200;
  localparam int CN   = 3;
  localparam int SC   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fv = 1'b0, bv = 1'b0;
  logic [11:0] fmm = '0, bmm = '0;
  logic [1:0]  cmd = 2'b00;
  logic        stop_front, stop_back, stale_front, stale_back, motion_ok;

  always #5 clk = ~clk;

  proximity_guard #(
    .CLK_HZ   (1000),
    .NEAR_MM  (NEAR),
    .FAR_MM   (FAR),
    .CONFIRM_N(CN),
    .STALE_MS (SC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .front_valid(fv),
    .front_mm   (fmm),
    .back_valid (bv),
    .back_mm    (bmm),
    .cmd_dir    (cmd),
    .stop_front (stop_front),
    .stop_back  (stop_back),
    .stale_front(stale_front),
    .stale_back (stale_back),
    .motion_ok  (motion_ok)
  );

  int checks = 0;
  int fails  = 0;
  bit armed  = 0;

  // Behavioural model: "blocked" is the obstacle verdict, "run" counts consecutive
  // samples arguing against the current verdict, "idle" counts edges since the last
  // usable sample.
  bit m_blk[2];
  int m_run[2];
  int m_idle[2];
  bit m_seen[2];
  bit m_stop[2];
  bit m_stale[2];
  bit m_mo;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_blk[c] = 0; m_run[c] = 0; m_idle[c] = 0; m_seen[c] = 0;
      m_stop[c] = 1; m_stale[c] = 1;
    end
    m_mo = 0;
  endfunction

  function automatic void step_chan(input int c, input logic v, input logic [11:0] mm);
    bit near, far;
    if (v && mm != 0) begin
      m_idle[c] = 0;
      m_seen[c] = 1;
      near = (int'(mm) < NEAR);
      far  = (int'(mm) >= FAR);
      if (!m_blk[c]) begin
        if (near) begin
          m_run[c]++;
          if (m_run[c] == CN) begin m_blk[c] = 1; m_run[c] = 0; end
        end else if (far) m_run[c] = 0;
      end else begin
        if (far) begin
          m_run[c]++;
          if (m_run[c] == CN) begin m_blk[c] = 0; m_run[c] = 0; end
        end else if (near) m_run[c] = 0;
      end
    end else if (m_idle[c] < 100000) begin
      m_idle[c]++;
    end
    m_stale[c] = !m_seen[c] || (m_idle[c] > SC);
    m_stop[c]  = m_blk[c] || m_stale[c];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
      armed = 1;
    end else begin
      case (cmd)
        2'b00:   m_mo = 1;
        2'b01:   m_mo = !m_stop[0];
        2'b10:   m_mo = !m_stop[1];
        default: m_mo = 0;
      endcase
      step_chan(0, fv, fmm);
      step_chan(1, bv, bmm);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_stop_front",  stop_front,  int'(m_stop[0]));
      chk("model_stop_back",   stop_back,   int'(m_stop[1]));
      chk("model_stale_front", stale_front, int'(m_stale[0]));
      chk("model_stale_back",  stale_back,  int'(m_stale[1]));
      chk("model_motion_ok",   motion_ok,   int'(m_mo));
    end
  end

  task automatic send_f(input logic [11:0] mm);
    @(negedge clk); fv = 1'b1; fmm = mm;
    @(negedge clk); fv = 1'b0;
  endtask

  function automatic logic [11:0] pick();
    case ($urandom_range(0, 7))
      0:       return 12'd0;
      1:       return 12'(NEAR - 1);
      2:       return 12'(NEAR);
      3:       return 12'(FAR - 1);
      4:       return 12'(FAR);
      5:       return 12'($urandom_range(1, NEAR - 1));
      6:       return 12'($urandom_range(NEAR, FAR - 1));
      default: return 12'($urandom_range(FAR, 4095));
    endcase
  endfunction

  logic [1:0] cmds[4] = '{2'b01, 2'b10, 2'b00, 2'b11};
  int         mo_exp[4] = '{0, 1, 1, 0};

  initial begin
    int rate;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_stop_front", stop_front, 1);
    chk("rst_stop_back", stop_back, 1);
    chk("rst_stale_front", stale_front, 1);
    chk("rst_stale_back", stale_back, 1);
    chk("rst_motion_ok", motion_ok, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stale_front", stale_front, 1);

    // First far sample freshens and clears the front channel
    send_f(12'd2000);
    chk("s1_stale_front", stale_front, 0);
    chk("s1_stop_front", stop_front, 0);

    // Confirmation count and abort on far
    send_f(12'd800); send_f(12'd800); send_f(12'd2000);
    chk("s2_abort_stop", stop_front, 0);
    send_f(12'd800); chk("s2_near1", stop_front, 0);
    send_f(12'd800); chk("s2_near2", stop_front, 0);
    send_f(12'd800); chk("s2_near3_blocked", stop_front, 1);

    // Hysteresis band holds, release needs three far samples
    for (int i = 0; i < 5; i++) begin
      send_f(12'd1100);
      chk("s3_band_hold", stop_front, 1);
    end
    send_f(12'd1300); chk("s3_rel1", stop_front, 1);
    send_f(12'd1300); chk("s3_rel2", stop_front, 1);
    send_f(12'd1300); chk("s3_rel3_clear", stop_front, 0);
    send_f(12'd800); send_f(12'd800); send_f(12'd800);
    chk("s3_reblocked", stop_front, 1);
    send_f(12'd1300); chk("s3_releasing", stop_front, 1);
    send_f(12'd900);  chk("s3_back_to_blocked", stop_front, 1);
    send_f(12'd1300); send_f(12'd1300);
    chk("s3_partial_release", stop_front, 1);

    // Motion permit with front stopped, back kept fresh and clear
    @(negedge clk); bv = 1'b1; bmm = 12'd2000;
    @(negedge clk);
    chk("s5_stop_front", stop_front, 1);
    chk("s5_stop_back", stop_back, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cmd = cmds[i];
      @(negedge clk); chk("s5_motion_ok", motion_ok, mo_exp[i]);
    end
    bv = 1'b0; cmd = 2'b00;

    // Staleness: expires on the 6th idle edge; mm=0 pulses do not refresh
    send_f(12'd2000);
    chk("s4_fresh0", stale_front, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); fv = (i == 1); fmm = 12'd0;
      chk("s4_fresh", stale_front, 0);
    end
    @(negedge clk); fv = 1'b0;
    chk("s4_expired", stale_front, 1);
    send_f(12'd2000);
    chk("s4_refresh", stale_front, 0);
    repeat (4) @(negedge clk);
    chk("s4_before_expiry", stale_front, 0);
    send_f(12'd2000);
    chk("s4_sample_wins", stale_front, 0);

    // Reset mid-ARMING discards the partial count
    send_f(12'd2000); send_f(12'd2000); send_f(12'd2000);
    send_f(12'd800); send_f(12'd800);
    chk("s6_arming", stop_front, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("s6_rst_stop_front", stop_front, 1);
    chk("s6_rst_stale_front", stale_front, 1);
    chk("s6_rst_motion_ok", motion_ok, 0);
    send_f(12'd800);
    chk("s6_single_near", stop_front, 0);
    chk("s6_single_near_fresh", stale_front, 0);

    // Randomized phase, checked every cycle against the model
    rate = 2;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc % 64 == 0) rate = $urandom_range(0, 3);
      rst = ($urandom_range(0, 499) == 0);
      fv  = (rate != 0) && ($urandom_range(0, rate) == 0);
      fmm = pick();
      bv  = (rate != 0) && ($urandom_range(0, rate) == 0);
      bmm = pick();
      if ($urandom_range(0, 7) == 0) cmd = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst = 1'b0; fv = 1'b0; bv = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
